// File: rtl/rst_seq_pkg.sv
// Shared types and widths for the reset sequencer and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rst_seq_pkg;

  localparam int CNT_W      = 16;
  localparam int IDX_W      = 2;
  localparam int MAX_STAGES = 4;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_DELAY,
    ST_WAIT_ACK,
    ST_READY,
    ST_FAULT
  } seq_state_t;

endpackage

// File: rtl/rst_sync_cell.sv
// Asynchronous-assert / synchronous-deassert reset synchroniser chain.
// Latency: deassertion seen SYNC_STAGES clocks after rst falls; assertion immediate.
// Backpressure: none.
module rst_sync_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_25m,
  input  logic rst,
  output logic rst_sync
);

  logic [SYNC_STAGES-1:0] chain;

  // Chain is forced to all ones by rst and shifts zeros in once rst is low.
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Releases up to four stage resets in order, each after a delay and the previous ack.
// Latency: first release SYNC_STAGES+STAGE_DLY+1 clocks after rst falls; outputs registered.
// Backpressure: waits on stage_ack level; missing/lost ack latches a sticky fault.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int STAGES      = 3,
  parameter int STAGE_DLY   = 16,
  parameter int ACK_TIMEOUT = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_25m,
  input  logic              rst,
  input  logic [STAGES-1:0] stage_ack,
  output logic [STAGES-1:0] stage_rst,
  output logic              all_ready,
  output logic              timeout_err,
  output logic [IDX_W-1:0]  fail_stage
);

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STAGES - 1);

  logic rst_sync;

  rst_sync_cell #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_25m (clk_25m),
    .rst     (rst),
    .rst_sync(rst_sync)
  );

  seq_state_t        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [STAGES-1:0] stage_rst_d;
  logic              all_ready_d;
  logic              timeout_err_d;
  logic [IDX_W-1:0]  fail_stage_d;
  logic              ack_cur;
  logic              lost;
  logic [IDX_W-1:0]  lost_idx;

  // Select the ack of the stage currently being waited on.
  always_comb begin
    ack_cur = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (IDX_W'(i) == idx) ack_cur = stage_ack[i];
    end
  end

  // Find the lowest-numbered stage whose ack has dropped (all are released in READY).
  always_comb begin
    lost     = 1'b0;
    lost_idx = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (!stage_ack[i]) begin
        lost     = 1'b1;
        lost_idx = IDX_W'(i);
      end
    end
  end

  // Next-state, counter and output decode; every output is registered below.
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    idx_d         = idx;
    stage_rst_d   = stage_rst;
    all_ready_d   = all_ready;
    timeout_err_d = timeout_err;
    fail_stage_d  = fail_stage;
    unique case (state)
      ST_HOLD: begin
        if (!rst_sync) begin
          state_d = ST_DELAY;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_DELAY: begin
        if (cnt == DLY_LAST) begin
          for (int i = 0; i < STAGES; i++) begin
            if (IDX_W'(i) == idx) stage_rst_d[i] = 1'b0;
          end
          cnt_d   = '0;
          state_d = ST_WAIT_ACK;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_WAIT_ACK: begin
        cnt_d = cnt + CNT_W'(1);
        // Ack is checked first so a same-edge ack beats the timeout.
        if (ack_cur) begin
          if (idx == IDX_LAST) begin
            state_d     = ST_READY;
            all_ready_d = 1'b1;
          end else begin
            idx_d   = idx + IDX_W'(1);
            cnt_d   = '0;
            state_d = ST_DELAY;
          end
        end else if (cnt == TMO_LAST) begin
          state_d       = ST_FAULT;
          stage_rst_d   = '1;
          all_ready_d   = 1'b0;
          timeout_err_d = 1'b1;
          fail_stage_d  = idx;
        end
      end
      ST_READY: begin
        if (lost) begin
          state_d       = ST_FAULT;
          stage_rst_d   = '1;
          all_ready_d   = 1'b0;
          timeout_err_d = 1'b1;
          fail_stage_d  = lost_idx;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  // State, counters and registered outputs; rst forces everything back immediately.
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      state       <= ST_HOLD;
      cnt         <= '0;
      idx         <= '0;
      stage_rst   <= '1;
      all_ready   <= 1'b0;
      timeout_err <= 1'b0;
      fail_stage  <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      idx         <= idx_d;
      stage_rst   <= stage_rst_d;
      all_ready   <= all_ready_d;
      timeout_err <= timeout_err_d;
      fail_stage  <= fail_stage_d;
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: nominal, timeout, coincidence, early ack, lost ack, mid reset.
// Latency: checks sampled 1 time unit after each rising edge, edges counted from rst release.
// Backpressure: acks driven directly by the sequence below.
module tb_rst_sequencer;

  localparam int STAGES      = 3;
  localparam int STAGE_DLY   = 4;
  localparam int ACK_TIMEOUT = 8;
  localparam int SYNC_STAGES = 2;

  logic              clk_25m;
  logic              rst;
  logic [STAGES-1:0] stage_ack;
  logic [STAGES-1:0] stage_rst;
  logic              all_ready;
  logic              timeout_err;
  logic [1:0]        fail_stage;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  rst_sequencer #(
    .STAGES     (STAGES),
    .STAGE_DLY  (STAGE_DLY),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_25m    (clk_25m),
    .rst        (rst),
    .stage_ack  (stage_ack),
    .stage_rst  (stage_rst),
    .all_ready  (all_ready),
    .timeout_err(timeout_err),
    .fail_stage (fail_stage)
  );

  initial begin
    clk_25m = 1'b0;
    forever #20 clk_25m = ~clk_25m;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s at edge %0d: observed %0h required %0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25m);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) tick();
  endtask

  // Assert rst away from a clock edge, check reset values, release on a falling edge.
  task automatic restart(input logic [2:0] ack_init);
    #5;
    rst       = 1'b1;
    stage_ack = ack_init;
    #1;
    chk("rst_stage_rst", 8'(stage_rst), 8'h07);
    chk("rst_all_ready", 8'(all_ready), 8'h00);
    chk("rst_timeout_err", 8'(timeout_err), 8'h00);
    chk("rst_fail_stage", 8'(fail_stage), 8'h00);
    @(negedge clk_25m);
    rst    = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    rst       = 1'b1;
    stage_ack = '0;

    // Nominal: each stage acks two edges after its release.
    restart(3'b000);
    run_to(6);  chk("nom_e6_rst", 8'(stage_rst), 8'h07);
    run_to(7);  chk("nom_e7_rst", 8'(stage_rst), 8'h06);
    run_to(8);  stage_ack[0] = 1'b1;
    run_to(12); chk("nom_e12_rst", 8'(stage_rst), 8'h06);
    run_to(13); chk("nom_e13_rst", 8'(stage_rst), 8'h04);
    run_to(14); stage_ack[1] = 1'b1;
    run_to(18); chk("nom_e18_rst", 8'(stage_rst), 8'h04);
    run_to(19); chk("nom_e19_rst", 8'(stage_rst), 8'h00);
                chk("nom_e19_ready", 8'(all_ready), 8'h00);
    run_to(20); stage_ack[2] = 1'b1;
                chk("nom_e20_ready", 8'(all_ready), 8'h00);
    run_to(21); chk("nom_e21_ready", 8'(all_ready), 8'h01);
                chk("nom_e21_err", 8'(timeout_err), 8'h00);

    // Lost ack in READY: stages 2 and 0 drop together, lowest index reported.
    run_to(23); chk("lost_e23_ready", 8'(all_ready), 8'h01);
    stage_ack = 3'b010;
    run_to(24); chk("lost_err", 8'(timeout_err), 8'h01);
                chk("lost_fail_stage", 8'(fail_stage), 8'h00);
                chk("lost_ready", 8'(all_ready), 8'h00);
                chk("lost_rst", 8'(stage_rst), 8'h07);

    // Timeout: stage 1 never acks; released at 13, fault at 21, terminal.
    restart(3'b000);
    run_to(8);  stage_ack[0] = 1'b1;
    run_to(13); chk("tmo_e13_rst", 8'(stage_rst), 8'h04);
    run_to(20); chk("tmo_e20_err", 8'(timeout_err), 8'h00);
                chk("tmo_e20_rst", 8'(stage_rst), 8'h04);
    run_to(21); chk("tmo_e21_err", 8'(timeout_err), 8'h01);
                chk("tmo_e21_fail", 8'(fail_stage), 8'h01);
                chk("tmo_e21_rst", 8'(stage_rst), 8'h07);
                chk("tmo_e21_ready", 8'(all_ready), 8'h00);
    run_to(25); stage_ack = 3'b111;
    run_to(40); chk("tmo_hold_err", 8'(timeout_err), 8'h01);
                chk("tmo_hold_rst", 8'(stage_rst), 8'h07);
                chk("tmo_hold_ready", 8'(all_ready), 8'h00);

    // Ack arriving on the timeout edge counts as success.
    restart(3'b000);
    run_to(7);  chk("coin_e7_rst", 8'(stage_rst), 8'h06);
    run_to(14); stage_ack[0] = 1'b1;
                chk("coin_e14_err", 8'(timeout_err), 8'h00);
    run_to(15); chk("coin_e15_err", 8'(timeout_err), 8'h00);
                chk("coin_e15_rst", 8'(stage_rst), 8'h06);
    run_to(18); chk("coin_e18_rst", 8'(stage_rst), 8'h06);
    run_to(19); chk("coin_e19_rst", 8'(stage_rst), 8'h04);
                chk("coin_e19_err", 8'(timeout_err), 8'h00);

    // Early ack: all acks high before release.
    restart(3'b111);
    run_to(6);  chk("early_e6_rst", 8'(stage_rst), 8'h07);
    run_to(7);  chk("early_e7_rst", 8'(stage_rst), 8'h06);
    run_to(11); chk("early_e11_rst", 8'(stage_rst), 8'h06);
    run_to(12); chk("early_e12_rst", 8'(stage_rst), 8'h04);
    run_to(16); chk("early_e16_rst", 8'(stage_rst), 8'h04);
    run_to(17); chk("early_e17_rst", 8'(stage_rst), 8'h00);
                chk("early_e17_ready", 8'(all_ready), 8'h00);
    run_to(18); chk("early_e18_ready", 8'(all_ready), 8'h01);
                chk("early_e18_err", 8'(timeout_err), 8'h00);

    // Reset asserted mid-cycle while waiting on stage 1's ack.
    restart(3'b000);
    run_to(8);  stage_ack[0] = 1'b1;
    run_to(15); chk("mid_e15_rst", 8'(stage_rst), 8'h04);
    restart(3'b000);
    run_to(6);  chk("mid_re6_rst", 8'(stage_rst), 8'h07);
    run_to(7);  chk("mid_re7_rst", 8'(stage_rst), 8'h06);
                chk("mid_re7_err", 8'(timeout_err), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Consumes the system reset produced by the power-on reset generator, inverted at top level to active-high, and drives ordered per-subsystem resets on the 25 MHz clock. It synchronises reset deassertion, then releases up to four downstream stages one at a time. A stage is released only after a programmable delay and after the previous stage acknowledges init-done. Ack timeouts and lost acks are latched as faults.

## Interface
- `STAGES`, 3: number of sequenced stages, legal 1..4.
- `STAGE_DLY`, 16: cycles between entering DELAY and releasing the stage, legal ≥1.
- `ACK_TIMEOUT`, 255: maximum cycles to wait for a stage ack after its release, legal 1..65535.
- `SYNC_STAGES`, 2: depth of the reset-deassert synchroniser, legal ≥2.
- `clk_25m` in, 1: single clock.
- `rst` in, 1: reset, asynchronous, active-high.
- `stage_ack` in, STAGES: per-stage init-done, same clock domain, level.
- `stage_rst` out, STAGES: per-stage reset, active-high, registered.
- `all_ready` out, 1: all stages released and acked.
- `timeout_err` out, 1: sticky fault flag.
- `fail_stage` out, 2: index of the faulting stage; valid while `timeout_err` is 1.

## Operation
- **Reset values**, asynchronous on `rst`: `stage_rst` all ones, `all_ready` 0, `timeout_err` 0, `fail_stage` 0, state HOLD, index 0, counters 0.
- **Synchroniser**: a SYNC_STAGES-deep chain, asynchronously set by `rst`, shifting in 0. It produces `rst_sync`.
- **FSM states**: HOLD, DELAY, WAIT_ACK, READY, FAULT.
- **HOLD**: stay while `rst_sync` is 1. Move to DELAY with cnt=0 and idx=0.
- **DELAY**: increment cnt. When cnt==STAGE_DLY-1:
  - clear `stage_rst[idx]`,
  - clear cnt,
  - move to WAIT_ACK.
- **WAIT_ACK**: sample `stage_ack[idx]` every cycle and increment cnt.
  - If ack is 1 and idx==STAGES-1: move to READY and set `all_ready`.
  - If ack is 1 otherwise: idx++, cnt=0, move to DELAY.
  - If ack is 0 and cnt==ACK_TIMEOUT-1: move to FAULT.
  - Ack wins over timeout on the same edge.
  - An ack already high at release is accepted on the first WAIT_ACK edge.
- **READY**: monitor every released stage. If any `stage_ack[i]` falls, move to FAULT with `fail_stage` set to the lowest such i.
- **FAULT**: on entry, register the following on the same edge:
  - `stage_rst` all ones,
  - `all_ready` 0,
  - `timeout_err` 1,
  - `fail_stage` = faulting index.
  
  FAULT is terminal and exits only via `rst`.
- **Other rules**:
  - Acks of unreleased stages are ignored.
  - Stage i is never released before stage i-1 is acked.
  - At most one `stage_rst` bit falls per edge.
  - `rst` asserted mid-sequence or in READY/FAULT immediately returns every output to its reset value.
- **Arithmetic**: cnt is 16 bits with no wrap in normal operation, because the terminal compare precedes overflow. idx is 2 bits.

## Timing
- Count edges from the first rising edge after `rst` falls as edge 1.
- `rst_sync` falls after edge SYNC_STAGES. HOLD→DELAY occurs on edge SYNC_STAGES+1.
- `stage_rst[0]` falls on edge SYNC_STAGES+STAGE_DLY+1. With defaults this is edge 19.
- Ack for stage i sampled high at edge m:
  - `stage_rst[i+1]` falls at edge m+STAGE_DLY.
  - For the last stage, `all_ready` rises at edge m.
- Stage released at edge r with ack never high: FAULT outputs appear at edge r+ACK_TIMEOUT.
- Ack first high at edge r+ACK_TIMEOUT: success, no fault.
- Lost ack in READY, sampled low at edge m: `timeout_err` is 1 and `stage_rst` is all ones after edge m.
- All outputs are registered, so there is no combinational path from `stage_ack` to any output.

## Structure
- **Shared package `rst_seq_pkg`**:
  - FSM state enum,
  - `CNT_W`=16,
  - `IDX_W`=2,
  - `MAX_STAGES`=4.
- **Sub-module `rst_sync_cell`**: the asynchronous-assert / synchronous-deassert chain, parameterised by SYNC_STAGES. It is reused elsewhere for other reset crossings.
- **Top**: the FSM and counters.

## Test plan
All scenarios use STAGES=3, STAGE_DLY=4, ACK_TIMEOUT=8, SYNC_STAGES=2.
- **Nominal**: release `rst`; ack each stage 2 edges after its release. `stage_rst[0]` falls at edge 7, `stage_rst[1]` at 13, `stage_rst[2]` at 19; `all_ready` rises at 21.
- **Timeout**: stage 1 never acks. At edge 13+8=21: `timeout_err`=1, `fail_stage`=1, `stage_rst`=3'b111. State holds until `rst`.
- **Ack/timeout coincidence**: stage 0 ack first high at edge 7+8=15. This is success and `stage_rst[1]` falls at edge 19.
- **Early ack**: all `stage_ack` tied 1 before `rst` release. Releases at edges 7, 12, 17; `all_ready` rises at 18; no fault.
- **Lost ack**: in READY, drop `stage_ack[2]` and `stage_ack[0]` together. Next edge: `timeout_err`=1, `fail_stage`=0, `all_ready`=0.
- **Reset mid-operation**: assert `rst` asynchronously mid-cycle while in WAIT_ACK for stage 1. All outputs take reset values before the next edge. On release, the sequence restarts with `stage_rst[0]` falling at edge 7.
